imem_init_rx: RTL and testbench

- Receiving end of the CPU instruction-initialization bus: `initialize`, `instruction_initialize_address`, `instruction_initialize_data`.
- Captures word writes into an instruction RAM and rejects misaligned, out-of-range or duplicate writes.
- After `initialize` drops, verifies the loaded image by readback checksum, then asserts `cpu_run`.
- Provides the combinational fetch port used by the single-cycle CPU datapath.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_ram.sv | 27 ++
 rtl/imem_init_rx.sv | 154 +++++++++++++++
 tb/tb_imem_init_rx.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory init receiver.
package imem_pkg;

    localparam int          IMEM_DEPTH = 64;
    localparam int          IMEM_IDX_W = 6;
    localparam logic [31:0] NOP_WORD   = 32'h0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        RUN,
        FAULT
    } state_t;

    // Byte address to word index; the low two bits select a byte and are dropped.
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, two asynchronous read ports.
// Contents have no reset so a loaded image survives a controller reset.
module imem_ram #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] fetch_addr,
    output logic [31:0]      fetch_data,
    input  logic [IDX_W-1:0] scan_addr,
    output logic [31:0]      scan_data
);

    logic [31:0] mem [DEPTH];

    // Word write from the init bus
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign fetch_data = mem[fetch_addr];
    assign scan_data  = mem[scan_addr];

endmodule

// File: rtl/imem_init_rx.sv
// Init-bus receiver: loads the instruction RAM, rejects bad writes, verifies
// the image by readback checksum and then releases the CPU.
module imem_init_rx
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int IDX_W = IMEM_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             initialize,
    input  logic [31:0]      instruction_initialize_address,
    input  logic [31:0]      instruction_initialize_data,
    input  logic [31:0]      fetch_pc,
    output logic [31:0]      fetch_instr,
    output logic             cpu_run,
    output logic             load_error,
    output logic [IDX_W:0]   load_count,
    output logic             verify_busy
);

    localparam logic [29:0]  DEPTH_W = 30'(DEPTH);
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);

    state_t             state, state_n;
    logic [DEPTH-1:0]   valid, valid_n, base_valid;
    logic [31:0]        chk, chk_n, base_chk;
    logic [31:0]        rb, rb_n;
    logic [IDX_W:0]     hwm, hwm_n, base_hwm;
    logic [IDX_W:0]     scan, scan_n;
    logic [IDX_W:0]     count_n, base_count;
    logic               err_n, base_err;

    logic [29:0]        widx, fidx;
    logic [IDX_W-1:0]   wslot;
    logic [IDX_W:0]     wslot_end;
    logic               restart, bad, ram_we;
    logic [31:0]        fetch_data, scan_data;
    logic               unused_pc_bits;

    assign widx      = word_index(instruction_initialize_address);
    assign wslot     = widx[IDX_W-1:0];
    assign wslot_end = {1'b0, wslot} + ONE_C;
    assign fidx      = word_index(fetch_pc);
    assign unused_pc_bits = ^fetch_pc[1:0];

    // Reasserting initialize after a load wipes the bookkeeping; the write in
    // that same cycle is judged against the wiped state.
    assign restart    = initialize && (state inside {VERIFY, RUN, FAULT});
    assign base_valid = restart ? '0 : valid;
    assign base_chk   = restart ? '0 : chk;
    assign base_hwm   = restart ? '0 : hwm;
    assign base_count = restart ? '0 : load_count;
    assign base_err   = restart ? 1'b0 : load_error;

    assign bad = (instruction_initialize_address[1:0] != 2'b00) ||
                 (widx >= DEPTH_W) ||
                 base_valid[wslot];

    imem_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
        .clk        (clk),
        .we         (ram_we),
        .waddr      (wslot),
        .wdata      (instruction_initialize_data),
        .fetch_addr (fidx[IDX_W-1:0]),
        .fetch_data (fetch_data),
        .scan_addr  (scan[IDX_W-1:0]),
        .scan_data  (scan_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Bitmap, checksums, counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid      <= '0;
            chk        <= '0;
            rb         <= '0;
            hwm        <= '0;
            scan       <= '0;
            load_count <= '0;
            load_error <= 1'b0;
        end else begin
            valid      <= valid_n;
            chk        <= chk_n;
            rb         <= rb_n;
            hwm        <= hwm_n;
            scan       <= scan_n;
            load_count <= count_n;
            load_error <= err_n;
        end
    end

    // Next-state: write acceptance while loading, readback scan, compare
    always_comb begin
        state_n = state;
        valid_n = valid;
        chk_n   = chk;
        rb_n    = rb;
        hwm_n   = hwm;
        scan_n  = scan;
        count_n = load_count;
        err_n   = load_error;
        ram_we  = 1'b0;
        if (initialize) begin
            state_n = LOAD;
            valid_n = base_valid;
            chk_n   = base_chk;
            hwm_n   = base_hwm;
            count_n = base_count;
            err_n   = base_err;
            if (bad) begin
                err_n = 1'b1;
            end else begin
                ram_we         = 1'b1;
                valid_n[wslot] = 1'b1;
                chk_n          = base_chk ^ instruction_initialize_data;
                if (base_count < DEPTH_C) count_n = base_count + ONE_C;
                if (wslot_end > base_hwm) hwm_n = wslot_end;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (load_error || load_count == '0) begin
                        state_n = FAULT;
                    end else begin
                        state_n = VERIFY;
                        scan_n  = '0;
                        rb_n    = '0;
                    end
                end
                VERIFY: begin
                    if (scan < hwm) begin
                        if (valid[scan[IDX_W-1:0]]) rb_n = rb ^ scan_data;
                        scan_n = scan + ONE_C;
                    end else begin
                        state_n = (rb == chk) ? RUN : FAULT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_run     = (state == RUN);
    assign verify_busy = (state == VERIFY);
    assign fetch_instr = (cpu_run && fidx < DEPTH_W) ? fetch_data : NOP_WORD;

endmodule

// File: tb/tb_imem_init_rx.sv
// Scoreboard bench for imem_init_rx: stimulus queues expectations, monitors
// compare when the DUT finishes a load or a probe is sampled.
module tb_imem_init_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        initialize = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] idata = '0;
    logic [31:0] fetch_pc = '0;
    logic [31:0] fetch_instr;
    logic        cpu_run, load_error, verify_busy;
    logic [6:0]  load_count;

    int n_cmp = 0;
    int n_bad = 0;

    imem_init_rx dut (
        .clk                            (clk),
        .rst                            (rst),
        .initialize                     (initialize),
        .instruction_initialize_address (iaddr),
        .instruction_initialize_data    (idata),
        .fetch_pc                       (fetch_pc),
        .fetch_instr                    (fetch_instr),
        .cpu_run                        (cpu_run),
        .load_error                     (load_error),
        .load_count                     (load_count),
        .verify_busy                    (verify_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [31:0] exp;
    } probe_t;

    typedef struct {
        int         busy;
        logic       run;
        logic       err;
        logic [6:0] cnt;
    } done_t;

    probe_t probe_q[$];
    string  probe_nm[$];
    done_t  done_q[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Probe monitor: samples every queued probe at the falling edge
    always @(negedge clk) begin
        probe_t      p;
        string       nm;
        logic [31:0] act;
        while (probe_q.size() > 0) begin
            p  = probe_q.pop_front();
            nm = probe_nm.pop_front();
            case (p.sel)
                0:       act = {31'b0, cpu_run};
                1:       act = {31'b0, load_error};
                2:       act = {25'b0, load_count};
                3:       act = {31'b0, verify_busy};
                default: act = fetch_instr;
            endcase
            cmp(nm, act, p.exp);
        end
    end

    // Load-completion monitor: after initialize falls, count verify_busy
    // cycles until the DUT settles in RUN or FAULT
    bit init_at_edge = 1'b0;
    always @(posedge clk) init_at_edge <= initialize;

    bit armed = 1'b0;
    int busy_len = 0;
    always @(negedge clk) begin
        done_t d;
        if (!rst) begin
            armed    = 1'b0;
            busy_len = 0;
        end else if (init_at_edge) begin
            armed    = 1'b1;
            busy_len = 0;
        end else if (armed) begin
            if (verify_busy) begin
                busy_len++;
            end else begin
                armed = 1'b0;
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL load_done: unexpected completion busy=%0d", busy_len);
                end else begin
                    d = done_q.pop_front();
                    cmp("verify_busy_cycles", busy_len, d.busy);
                    cmp("done_cpu_run", {31'b0, cpu_run}, {31'b0, d.run});
                    cmp("done_load_error", {31'b0, load_error}, {31'b0, d.err});
                    cmp("done_load_count", {25'b0, load_count}, {25'b0, d.cnt});
                end
            end
        end
    end

    task automatic probe(input int sel, input logic [31:0] exp, input string nm);
        probe_t p;
        p.sel = sel;
        p.exp = exp;
        probe_q.push_back(p);
        probe_nm.push_back(nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        initialize = 1'b1;
        iaddr      = a;
        idata      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic end_load(input int busy, input logic run, input logic err, input logic [6:0] cnt);
        done_t d;
        d.busy = busy;
        d.run  = run;
        d.err  = err;
        d.cnt  = cnt;
        done_q.push_back(d);
        initialize = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (done_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_done: timed out with %0d pending", done_q.size());
            done_q.delete();
        end
    endtask

    task automatic fetch_chk(input logic [31:0] pc, input logic [31:0] exp, input string nm);
        fetch_pc = pc;
        probe(4, exp, nm);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] basic_word(input int i);
        if (i == 0) return 32'h20010001;
        if (i == 5) return 32'h08000006;
        return 32'h00001000 + i;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        probe(0, 0, "rst_cpu_run");
        probe(1, 0, "rst_load_error");
        probe(2, 0, "rst_load_count");
        probe(3, 0, "rst_verify_busy");
        fetch_chk(32'h0, 32'h0, "rst_fetch");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic load: 9 words, hwm 9 -> 10 busy cycles
        for (int i = 0; i < 9; i++) wr(32'(4 * i), basic_word(i));
        probe(2, 9, "basic_count");
        probe(1, 0, "basic_err");
        end_load(10, 1'b1, 1'b0, 7'd9);
        wait_done();
        fetch_chk(32'd20,  32'h08000006, "fetch_20");
        fetch_chk(32'd0,   32'h20010001, "fetch_0");
        fetch_chk(32'd22,  32'h08000006, "fetch_low_bits_ignored");
        fetch_chk(32'd40,  32'h0,        "fetch_40");
        fetch_chk(32'd256, 32'h0,        "fetch_out_of_range");

        // Reload from RUN
        wr(32'd0, 32'h20010001);
        probe(0, 0, "reload_cpu_run");
        probe(2, 1, "reload_count");
        end_load(2, 1'b1, 1'b0, 7'd1);
        wait_done();
        fetch_chk(32'd0,  32'h20010001, "reload_fetch_0");
        fetch_chk(32'd20, 32'h08000006, "reload_ram_retained");

        // Misaligned write inside a good load
        wr(32'd0, 32'h30000000);
        wr(32'd4, 32'h30000001);
        wr(32'd6, 32'h3000dead);
        probe(1, 1, "misaligned_err");
        wr(32'd8, 32'h30000002);
        probe(2, 3, "misaligned_count");
        end_load(0, 1'b0, 1'b1, 7'd3);
        wait_done();
        fetch_chk(32'd0, 32'h0, "fault_fetch");

        // Out of range from FAULT; restart clears the sticky error first
        wr(32'd0, 32'h40000000);
        probe(1, 0, "restart_err_cleared");
        wr(32'd256, 32'h4000dead);
        probe(1, 1, "oor_err");
        probe(2, 1, "oor_count");
        end_load(0, 1'b0, 1'b1, 7'd1);
        wait_done();

        // Duplicate write: second write to addr 8 rejected
        wr(32'd8,  32'hAAAA0001);
        wr(32'd12, 32'hCCCC0003);
        wr(32'd8,  32'hBBBB0002);
        probe(1, 1, "dup_err");
        probe(2, 2, "dup_count");
        end_load(0, 1'b0, 1'b1, 7'd2);
        wait_done();

        // Sparse load with holes: idx 0 and 4, hwm 5 -> 6 busy cycles
        wr(32'd0,  32'h11110000);
        wr(32'd16, 32'h22220004);
        end_load(6, 1'b1, 1'b0, 7'd2);
        wait_done();
        fetch_chk(32'd8,  32'hAAAA0001, "dup_kept_first");
        fetch_chk(32'd16, 32'h22220004, "sparse_fetch_16");

        // Async reset in the middle of VERIFY
        for (int i = 0; i < 4; i++) wr(32'(4 * i), 32'h50000000 + i);
        initialize = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        cmp("mid_verify_busy", {31'b0, verify_busy}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        cmp("areset_verify_busy", {31'b0, verify_busy}, 32'h0);
        cmp("areset_cpu_run",     {31'b0, cpu_run},     32'h0);
        cmp("areset_load_count",  {25'b0, load_count},  32'h0);
        cmp("areset_load_error",  {31'b0, load_error},  32'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Load from IDLE after reset
        wr(32'd0, 32'h60000000);
        end_load(2, 1'b1, 1'b0, 7'd1);
        wait_done();
        fetch_chk(32'd0, 32'h60000000, "post_reset_fetch");

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
